// File: rtl/interrupt_entry_sequencer_if.sv
// Request, strobe and vector signals between the core's execute stage and the
// interrupt entry/exit sequencer. The "slave" modport is the sequencer's view.
interface interrupt_entry_sequencer_if;
  logic        ext_irq_in;
  logic        timer_irq_in;
  logic        csr_mie_meie_in;
  logic        csr_mie_mtie_in;
  logic        stall_signal_in;
  logic        pipe_empty_in;
  logic        mret_signal_in;
  logic        interrupt_signal_out;
  logic        stacking_signal_out;
  logic        stack_push_out;
  logic        stack_pop_out;
  logic [3:0]  stack_index_out;
  logic        stall_signal_out;
  logic        flush_signal_out;
  logic        vector_valid_out;
  logic [63:0] vector_pc_out;
  logic [3:0]  cause_out;
  logic        return_interrupt_signal_out;
  logic        in_isr_out;

  modport master (
    output ext_irq_in, timer_irq_in, csr_mie_meie_in, csr_mie_mtie_in,
           stall_signal_in, pipe_empty_in, mret_signal_in,
    input  interrupt_signal_out, stacking_signal_out, stack_push_out,
           stack_pop_out, stack_index_out, stall_signal_out, flush_signal_out,
           vector_valid_out, vector_pc_out, cause_out,
           return_interrupt_signal_out, in_isr_out
  );

  modport slave (
    input  ext_irq_in, timer_irq_in, csr_mie_meie_in, csr_mie_mtie_in,
           stall_signal_in, pipe_empty_in, mret_signal_in,
    output interrupt_signal_out, stacking_signal_out, stack_push_out,
           stack_pop_out, stack_index_out, stall_signal_out, flush_signal_out,
           vector_valid_out, vector_pc_out, cause_out,
           return_interrupt_signal_out, in_isr_out
  );
endinterface

// File: rtl/interrupt_entry_sequencer.sv
// Interrupt entry/exit sequencer: accepts an irq, drains the pipe, pushes the
// return-address registers, vectors; on mret pops them back and returns.
module interrupt_entry_sequencer #(
  parameter int          NUM_STACK_REGS = 4,
  parameter logic [63:0] VECTOR_BASE    = 64'h100
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  interrupt_entry_sequencer_if.slave    bus
);

  localparam logic [3:0] LAST_IDX    = 4'(NUM_STACK_REGS - 1);
  localparam logic [3:0] CAUSE_EXT   = 4'd11;
  localparam logic [3:0] CAUSE_TIMER = 4'd7;

  typedef enum logic [2:0] {
    ST_IDLE, ST_DRAIN, ST_STACK, ST_VECTOR, ST_ISR, ST_UNSTACK, ST_RETURN
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  index_q, index_d;
  logic [3:0]  cause_q, cause_d;
  logic [63:0] vector_pc_q, vector_pc_d;

  logic ext_pending;
  logic pending;

  assign ext_pending = bus.ext_irq_in & bus.csr_mie_meie_in;
  assign pending     = ext_pending | (bus.timer_irq_in & bus.csr_mie_mtie_in);

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= ST_IDLE;
      index_q     <= '0;
      cause_q     <= '0;
      vector_pc_q <= '0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      cause_q     <= cause_d;
      vector_pc_q <= vector_pc_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves one unassigned and a latch is never inferred.
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    cause_d     = cause_q;
    vector_pc_d = vector_pc_q;

    bus.interrupt_signal_out        = 1'b0;
    bus.stacking_signal_out         = 1'b0;
    bus.stack_push_out              = 1'b0;
    bus.stack_pop_out               = 1'b0;
    bus.stack_index_out             = 4'd0;
    bus.stall_signal_out            = 1'b0;
    bus.flush_signal_out            = 1'b0;
    bus.vector_valid_out            = 1'b0;
    bus.return_interrupt_signal_out = 1'b0;
    bus.in_isr_out                  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pending && !bus.stall_signal_in) begin
          state_d     = ST_DRAIN;
          cause_d     = ext_pending ? CAUSE_EXT : CAUSE_TIMER;
          vector_pc_d = VECTOR_BASE + {58'd0, cause_d, 2'b00};
        end
      end
      ST_DRAIN: begin
        bus.stall_signal_out = 1'b1;
        if (bus.pipe_empty_in) begin
          state_d = ST_STACK;
          index_d = 4'd0;
        end
      end
      ST_STACK: begin
        bus.stacking_signal_out  = 1'b1;
        bus.stall_signal_out     = 1'b1;
        bus.stack_push_out       = 1'b1;
        bus.stack_index_out      = index_q;
        // Index 0 is only ever seen in the first push cycle.
        bus.interrupt_signal_out = (index_q == 4'd0);
        if (index_q == LAST_IDX) begin
          state_d = ST_VECTOR;
          index_d = 4'd0;
        end else begin
          index_d = index_q + 4'd1;
        end
      end
      ST_VECTOR: begin
        bus.vector_valid_out = 1'b1;
        bus.flush_signal_out = 1'b1;
        bus.in_isr_out       = 1'b1;
        state_d              = ST_ISR;
      end
      ST_ISR: begin
        bus.in_isr_out = 1'b1;
        if (bus.mret_signal_in) begin
          state_d = ST_UNSTACK;
          index_d = LAST_IDX;
        end
      end
      ST_UNSTACK: begin
        bus.stall_signal_out = 1'b1;
        bus.stack_pop_out    = 1'b1;
        bus.stack_index_out  = index_q;
        bus.in_isr_out       = 1'b1;
        if (index_q == 4'd0) begin
          state_d = ST_RETURN;
        end else begin
          index_d = index_q - 4'd1;
        end
      end
      ST_RETURN: begin
        bus.return_interrupt_signal_out = 1'b1;
        bus.flush_signal_out            = 1'b1;
        bus.in_isr_out                  = 1'b1;
        state_d                         = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.cause_out     = cause_q;
  assign bus.vector_pc_out = vector_pc_q;

endmodule
